seq_det_sched: RTL and testbench

Round-robin scheduler that shares one serial sequence detector (the single-bit-in, single-bit-out FSM family) among several word-level requesters. It accepts a parallel word from one requester, clears the detector, and shifts the word in MSB first. It counts detector hits over the word and reports the count with the requester ID. It sits between the requester blocks and the detector instance, and is the only driver of the detector's input.

---
 rtl/seq_det_sched_pkg.sv | 17 +
 rtl/seq_det_rr_arb.sv | 64 ++++++
 rtl/seq_det_sched.sv | 168 ++++++++++++++++
 tb/tb_seq_det_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_sched_pkg.sv
// Shared types and default sizing for the sequence-detector scheduler.
// The optional round-robin arbiter is enabled by defining SEQ_DET_SCHED_RR_EN.
package seq_det_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    FLUSH,
    REPORT
  } state_e;

  localparam int DEF_WORD_W  = 8;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_DET_LAT = 1;

endpackage

// File: rtl/seq_det_rr_arb.sv
// Requester arbiter: round-robin when SEQ_DET_SCHED_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no pointer state.
module seq_det_rr_arb #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
`ifdef SEQ_DET_SCHED_RR_EN
  input  logic             clk,
  input  logic             rst_n,
  input  logic             take,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_req
);

`ifdef SEQ_DET_SCHED_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int j;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    // Search upward from the pointer with wrap; first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_req && req[j]) begin
        any_req = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
    if (any_req) gnt[gnt_idx] = 1'b1;

    ptr_d = ptr_q;
    if (take) ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    // Scan downward so the lowest requesting index is the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    if (any_req) gnt[gnt_idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/seq_det_sched.sv
// Shares one serial sequence detector among N_REQ word requesters: grant, clear,
// shift MSB first, flush, then report hit count. Arbitration mode: SEQ_DET_SCHED_RR_EN.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DET_LAT = DEF_DET_LAT
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   word,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      det_clr,
  output logic                      det_in,
  input  logic                      det_out,
  output logic                      done,
  output logic [$clog2(N_REQ)-1:0]  done_id,
  output logic [CNT_W-1:0]          hit_cnt
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int FL_W  = $clog2(DET_LAT + 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [CNT_W-1:0]   hits_q, hits_d, hits_inc;
  logic [ID_W-1:0]    id_q, id_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               det_clr_q, det_clr_d;
  logic               det_in_q, det_in_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               arb_take;
  logic               sample;

  seq_det_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
`ifdef SEQ_DET_SCHED_RR_EN
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .take    (arb_take),
`endif
    .req     (req),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Arbitrate from a quiet IDLE, or from REPORT so the next grant lands right after done.
  assign arb_take = arb_any && (((state_q == IDLE) && !(|gnt_q)) || (state_q == REPORT));

  // det_out for bit j is valid DET_LAT cycles after it is driven.
  assign sample   = ((state_q == SHIFT) && (int'(bit_q) >= DET_LAT)) || (state_q == FLUSH);
  assign hits_inc = (sample && det_out && (hits_q != {CNT_W{1'b1}})) ? hits_q + 1'b1 : hits_q;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_d     = bit_q;
    flush_d   = flush_q;
    hits_d    = hits_q;
    id_d      = id_q;
    gnt_d     = '0;
    det_in_d  = 1'b0;
    done_id_d = done_id_q;
    hit_cnt_d = hit_cnt_q;

    case (state_q)
      IDLE: begin
        if (|gnt_q) state_d = CLR;
      end
      CLR: begin
        state_d  = SHIFT;
        hits_d   = '0;
        bit_d    = '0;
        det_in_d = sreg_q[WORD_W-1];
        sreg_d   = sreg_q << 1;
      end
      SHIFT: begin
        hits_d = hits_inc;
        if (int'(bit_q) == WORD_W - 1) begin
          state_d = FLUSH;
          flush_d = '0;
        end else begin
          bit_d    = bit_q + 1'b1;
          det_in_d = sreg_q[WORD_W-1];
          sreg_d   = sreg_q << 1;
        end
      end
      FLUSH: begin
        hits_d = hits_inc;
        if (int'(flush_q) == DET_LAT - 1) begin
          state_d   = REPORT;
          done_id_d = id_q;
          hit_cnt_d = hits_inc;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (arb_take) begin
      gnt_d  = arb_gnt;
      id_d   = arb_idx;
      sreg_d = word[int'(arb_idx)*WORD_W +: WORD_W];
    end

    busy_d    = (state_d != IDLE);
    det_clr_d = (state_d == CLR);
    done_d    = (state_d == REPORT);
  end

  // NOTE: datapath registers are reset too, so outputs read 0 straight out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_q     <= '0;
      flush_q   <= '0;
      hits_q    <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      det_clr_q <= 1'b0;
      det_in_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_q     <= bit_d;
      flush_q   <= flush_d;
      hits_q    <= hits_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      det_clr_q <= det_clr_d;
      det_in_q  <= det_in_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign det_clr = det_clr_q;
  assign det_in  = det_in_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched with a one-cycle detector stub (det_out = det_in delayed).
// Expected grant order follows SEQ_DET_SCHED_RR_EN.
module tb_seq_det_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] word;
  logic [1:0]  gnt;
  logic        busy, det_clr, det_in, det_out, done;
  logic        done_id;
  logic [2:0]  hit_cnt;

  logic stub_q    = 1'b0;
  logic force_one = 1'b0;

  always #5 clk = ~clk;

  seq_det_sched #(.N_REQ(2), .WORD_W(8), .CNT_W(3), .DET_LAT(1)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .req       (req),
    .word      (word),
    .gnt       (gnt),
    .busy      (busy),
    .det_clr   (det_clr),
    .det_in    (det_in),
    .det_out   (det_out),
    .done      (done),
    .done_id   (done_id),
    .hit_cnt   (hit_cnt)
  );

  always @(posedge clk) stub_q <= det_clr ? 1'b0 : det_in;
  assign det_out = force_one ? 1'b1 : stub_q;

  typedef struct {
    logic [1:0] g;
    int         id;
    logic [7:0] w;
    int         cnt;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   active    = 1'b0;
  int   cyc       = 0;
  int   g_cyc     = 0;
  int   last_done = 0;
  int   checks    = 0;
  int   errors    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [1:0] g, input int id, input logic [7:0] w,
                      input int c, input bit b2b);
    exp_t e;
    e.g = g; e.id = id; e.w = w; e.cnt = c; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  // Monitor: pop on each grant, then follow the job cycle by cycle.
  always @(negedge clk) begin
    int d;
    cyc++;
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (gnt != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("gnt_onehot", 32'(gnt), 32'(cur.g));
          check("busy_at_gnt", 32'(busy), 32'd0);
          if (cur.b2b) check("gnt_after_done", cyc, last_done + 1);
          active = 1'b1;
          g_cyc  = cyc;
        end
      end
      if (active) begin
        d = cyc - g_cyc;
        if (d == 1) begin
          check("det_clr", 32'(det_clr), 32'd1);
          check("busy_clr", 32'(busy), 32'd1);
        end
        if (d >= 2 && d <= 9) check("det_in_bit", 32'(det_in), 32'(cur.w[9-d]));
        if (d == 10) check("det_in_flush", 32'(det_in), 32'd0);
        if (d == 11) begin
          check("done", 32'(done), 32'd1);
          check("busy_report", 32'(busy), 32'd1);
          check("done_id", 32'(done_id), 32'(cur.id));
          check("hit_cnt", 32'(hit_cnt), 32'(cur.cnt));
          active    = 1'b0;
          last_done = cyc;
        end else if (done) begin
          check("done_early", 32'(done), 32'd0);
        end
      end else if (done) begin
        check("done_unexpected", 32'(done), 32'd0);
      end
    end
  end

  task automatic wait_gnt();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) seen = 1'b1;
    end
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !active) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Called just after a negedge; holds reset across one posedge.
  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_det_clr", 32'(det_clr), 32'd0);
    check("rst_det_in", 32'(det_in), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    word  = 16'h0000;
    @(negedge clk);
    rst_pulse();
    @(negedge clk);

    // Single job; request and word change after grant must not disturb it.
    push(2'b01, 0, 8'b1101_1010, 5, 1'b0);
    word[7:0] = 8'b1101_1010;
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    word[7:0] = 8'h00;
    wait_idle();

    // Reset in IDLE clears held done_id/hit_cnt and the pointer.
    rst_pulse();
    @(negedge clk);

    // Both requesting continuously: four back-to-back jobs.
    word = {8'h03, 8'hF0};
`ifdef SEQ_DET_SCHED_RR_EN
    push(2'b01, 0, 8'hF0, 4, 1'b0);
    push(2'b10, 1, 8'h03, 2, 1'b1);
    push(2'b01, 0, 8'hF0, 4, 1'b1);
    push(2'b10, 1, 8'h03, 2, 1'b1);
`else
    push(2'b01, 0, 8'hF0, 4, 1'b0);
    push(2'b01, 0, 8'hF0, 4, 1'b1);
    push(2'b01, 0, 8'hF0, 4, 1'b1);
    push(2'b01, 0, 8'hF0, 4, 1'b1);
`endif
    req = 2'b11;
    for (int k = 0; k < 4; k++) wait_gnt();
    req = 2'b00;
    wait_idle();

    // Requester 1 alone.
    push(2'b10, 1, 8'h3C, 4, 1'b0);
    word[15:8] = 8'h3C;
    req = 2'b10;
    wait_gnt();
    req = 2'b00;
    wait_idle();

    // Eight hits into a 3-bit counter saturate at 7.
    push(2'b01, 0, 8'hFF, 7, 1'b0);
    word[7:0] = 8'hFF;
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_idle();

    // Reset during SHIFT bit 4 aborts the job; a fresh job restarts from the MSB.
    push(2'b01, 0, 8'hA5, 4, 1'b0);
    word[7:0] = 8'hA5;
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    repeat (6) @(negedge clk);
    exp_q.delete();
    rst_pulse();
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 32'(done), 32'd0);
    push(2'b01, 0, 8'hA5, 4, 1'b0);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_idle();

    // det_out stuck high during IDLE and CLR must not be counted.
    force_one = 1'b1;
    push(2'b01, 0, 8'h00, 0, 1'b0);
    word[7:0] = 8'h00;
    repeat (3) @(negedge clk);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    @(negedge clk);
    @(posedge clk);
    #1 force_one = 1'b0;
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
